// File: rtl/aes_gcm_pkg.sv
// rtl/aes_gcm_pkg.sv - shared state encoding, job select codes and J0/counter constants for the GCM scheduler
package aes_gcm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H_REQ,
        ST_H_WAIT,
        ST_J0_REQ,
        ST_J0_WAIT,
        ST_CTR_REQ,
        ST_CTR_WAIT,
        ST_FIN
    } state_t;

    localparam logic [1:0] SEL_H   = 2'd0;
    localparam logic [1:0] SEL_EJ0 = 2'd1;
    localparam logic [1:0] SEL_KS  = 2'd2;

    localparam logic [31:0] J0_LO   = 32'h0000_0001;
    localparam logic [31:0] CTR0_LO = 32'h0000_0002;

    function automatic logic [127:0] mk_blk(input logic [95:0] iv, input logic [31:0] lo);
        return {iv, lo};
    endfunction

endpackage

// File: rtl/aes_gcm_ctr32.sv
// rtl/aes_gcm_ctr32.sv - inc32 keystream counter with remaining-block count
module aes_gcm_ctr32 #(
    parameter int NUM_BLK_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [95:0]          load_iv,
    input  logic [31:0]          load_lo,
    input  logic [NUM_BLK_W-1:0] load_cnt,
    input  logic                 step,
    output logic [127:0]         ctr,
    output logic                 rem_zero,
    output logic                 rem_last
);

    logic [95:0]          iv_q, iv_d;
    logic [31:0]          lo_q, lo_d;
    logic [NUM_BLK_W-1:0] rem_q, rem_d;

    always_comb begin
        iv_d  = iv_q;
        lo_d  = lo_q;
        rem_d = rem_q;
        if (load) begin
            iv_d  = load_iv;
            lo_d  = load_lo;
            rem_d = load_cnt;
        end else if (step) begin
            // only the low word counts; the IV part never sees a carry
            lo_d = lo_q + 32'd1;
            if (rem_q != '0) begin
                rem_d = rem_q - NUM_BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q  <= '0;
            lo_q  <= '0;
            rem_q <= '0;
        end else begin
            iv_q  <= iv_d;
            lo_q  <= lo_d;
            rem_q <= rem_d;
        end
    end

    assign ctr      = {iv_q, lo_q};
    assign rem_zero = (rem_q == '0);
    assign rem_last = (rem_q == NUM_BLK_W'(1));

endmodule

// File: rtl/aes_gcm_sched.sv
// rtl/aes_gcm_sched.sv - GCM job scheduler for a shared AES core; AES_GCM_SCHED_H_REUSE_EN adds i_h_reuse to skip H
module aes_gcm_sched
    import aes_gcm_pkg::*;
#(
    parameter int NUM_BLK_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [95:0]          i_iv,
    input  logic [NUM_BLK_W-1:0] i_num_blk,
`ifdef AES_GCM_SCHED_H_REUSE_EN
    input  logic                 i_h_reuse,
`endif
    input  logic                 i_aes_ready,
    input  logic                 i_aes_done,
    input  logic                 i_ks_ready,
    output logic                 o_aes_start,
    output logic [127:0]         o_aes_blk,
    output logic [1:0]           o_aes_sel,
    output logic                 o_h_valid,
    output logic                 o_ej0_valid,
    output logic                 o_ks_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t state_q, state_d;

    logic         ctr_load;
    logic         ctr_step;
    logic [127:0] ctr;
    logic         rem_zero;
    logic         rem_last;
    logic         h_reuse;

`ifdef AES_GCM_SCHED_H_REUSE_EN
    assign h_reuse = i_h_reuse;
`else
    assign h_reuse = 1'b0;
`endif

    aes_gcm_ctr32 #(
        .NUM_BLK_W (NUM_BLK_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_iv  (i_iv),
        .load_lo  (CTR0_LO),
        .load_cnt (i_num_blk),
        .step     (ctr_step),
        .ctr      (ctr),
        .rem_zero (rem_zero),
        .rem_last (rem_last)
    );

    always_comb begin
        state_d     = state_q;
        o_aes_start = 1'b0;
        o_aes_blk   = 128'h0;
        o_aes_sel   = SEL_H;
        ctr_load    = 1'b0;
        ctr_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    ctr_load = 1'b1;
                    state_d  = h_reuse ? ST_J0_REQ : ST_H_REQ;
                end
            end
            ST_H_REQ: begin
                if (i_aes_ready) begin
                    o_aes_start = 1'b1;
                    state_d     = ST_H_WAIT;
                end
            end
            ST_H_WAIT: begin
                if (i_aes_done) begin
                    state_d = ST_J0_REQ;
                end
            end
            ST_J0_REQ: begin
                o_aes_blk = mk_blk(ctr[127:32], J0_LO);
                o_aes_sel = SEL_EJ0;
                if (i_aes_ready) begin
                    o_aes_start = 1'b1;
                    state_d     = ST_J0_WAIT;
                end
            end
            ST_J0_WAIT: begin
                o_aes_blk = mk_blk(ctr[127:32], J0_LO);
                o_aes_sel = SEL_EJ0;
                if (i_aes_done) begin
                    state_d = rem_zero ? ST_FIN : ST_CTR_REQ;
                end
            end
            ST_CTR_REQ: begin
                o_aes_blk = ctr;
                o_aes_sel = SEL_KS;
                // no point producing keystream the XOR stage cannot take
                if (i_aes_ready && i_ks_ready) begin
                    o_aes_start = 1'b1;
                    state_d     = ST_CTR_WAIT;
                end
            end
            ST_CTR_WAIT: begin
                o_aes_blk = ctr;
                o_aes_sel = SEL_KS;
                if (i_aes_done) begin
                    ctr_step = 1'b1;
                    state_d  = rem_last ? ST_FIN : ST_CTR_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_h_valid   = i_aes_done && (state_q == ST_H_WAIT);
    assign o_ej0_valid = i_aes_done && (state_q == ST_J0_WAIT);
    assign o_ks_valid  = i_aes_done && (state_q == ST_CTR_WAIT);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_aes_gcm_sched.sv
// tb/tb_aes_gcm_sched.sv - directed table-driven bench for aes_gcm_sched and the inc32 counter wrap
module tb_aes_gcm_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [95:0]  i_iv;
    logic [15:0]  i_num_blk;
    logic         h_reuse;
    logic         i_aes_ready;
    logic         i_aes_done;
    logic         i_ks_ready;
    logic         o_aes_start;
    logic [127:0] o_aes_blk;
    logic [1:0]   o_aes_sel;
    logic         o_h_valid;
    logic         o_ej0_valid;
    logic         o_ks_valid;
    logic         o_busy;
    logic         o_done;

    logic         w_load;
    logic         w_step;
    logic [127:0] w_ctr;
    logic         w_rem_zero;
    logic         w_rem_last;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_gcm_sched #(.NUM_BLK_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_iv        (i_iv),
        .i_num_blk   (i_num_blk),
`ifdef AES_GCM_SCHED_H_REUSE_EN
        .i_h_reuse   (h_reuse),
`endif
        .i_aes_ready (i_aes_ready),
        .i_aes_done  (i_aes_done),
        .i_ks_ready  (i_ks_ready),
        .o_aes_start (o_aes_start),
        .o_aes_blk   (o_aes_blk),
        .o_aes_sel   (o_aes_sel),
        .o_h_valid   (o_h_valid),
        .o_ej0_valid (o_ej0_valid),
        .o_ks_valid  (o_ks_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    aes_gcm_ctr32 #(.NUM_BLK_W(16)) u_wrap (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_iv  (96'hA5A5_0000_1111_2222_3333_4444),
        .load_lo  (32'hFFFF_FFFF),
        .load_cnt (16'd2),
        .step     (w_step),
        .ctr      (w_ctr),
        .rem_zero (w_rem_zero),
        .rem_last (w_rem_last)
    );

    typedef struct {
        logic [95:0]  iv;
        logic [15:0]  nblk;
        bit           stall;
        logic [127:0] exp_last;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input bit reuse, input int abort_at);
        int           ks_cnt;
        int           nl;
        int           w;
        logic [127:0] exp_blk;
        logic [1:0]   exp_sel;
        logic [127:0] last;
        ks_cnt     = 0;
        last       = '0;
        nl         = int'(v.nblk) + 2;
        i_ks_ready = !v.stall;
        i_iv       = v.iv;
        i_num_blk  = v.nblk;
        h_reuse    = reuse;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        #1;
        chk("busy_after_start", o_busy, 1);
        for (int l = (reuse ? 1 : 0); l < nl; l++) begin
            exp_blk = (l == 0) ? 128'h0 : {v.iv, 32'(l)};
            exp_sel = (l == 0) ? 2'd0 : ((l == 1) ? 2'd1 : 2'd2);
            if (l == 2 && v.stall) begin
                for (int c = 0; c < 10; c++) begin
                    i_start    = (c == 3);
                    i_aes_done = (c == 5);
                    #1;
                    chk("stall_no_start", o_aes_start, 0);
                    if (c == 5) chk("stall_stray_done", o_ks_valid, 0);
                    tick();
                end
                i_start    = 1'b0;
                i_aes_done = 1'b0;
                i_ks_ready = 1'b1;
            end
            #1;
            w = 0;
            while (!o_aes_start && w < 20) begin
                tick();
                #1;
                w++;
            end
            if (w == 20) begin
                chk("launch_timeout", 0, 1);
                return;
            end
            chk("launch_blk", o_aes_blk, exp_blk);
            chk("launch_sel", o_aes_sel, exp_sel);
            last = o_aes_blk;
            tick();
            if (l == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", o_busy, 0);
                chk("rst_blk", o_aes_blk, 0);
                chk("rst_start", o_aes_start, 0);
                tick();
                rst        = 1'b0;
                i_aes_done = 1'b1;
                #1;
                chk("rst_late_ks_valid", o_ks_valid, 0);
                chk("rst_late_busy", o_busy, 0);
                tick();
                i_aes_done = 1'b0;
                return;
            end
            repeat (3) tick();
            i_aes_done = 1'b1;
            #1;
            chk("wait_blk_stable", o_aes_blk, exp_blk);
            chk("h_valid", o_h_valid, exp_sel == 2'd0);
            chk("ej0_valid", o_ej0_valid, exp_sel == 2'd1);
            chk("ks_valid", o_ks_valid, exp_sel == 2'd2);
            if (o_ks_valid) ks_cnt++;
            chk("done_early", o_done, 0);
            tick();
            i_aes_done = 1'b0;
        end
        #1;
        chk("fin_done", o_done, 1);
        tick();
        #1;
        chk("done_one_cycle", o_done, 0);
        chk("idle_busy", o_busy, 0);
        chk("ks_count", 128'(ks_cnt), 128'(v.nblk));
        chk("last_blk", last, v.exp_last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{96'h1, 16'd3, 1'b0, {96'h1, 32'h4}};
        tbl[1] = '{96'hCAFE_BABE_DEAD_BEEF_0123_4567, 16'd0, 1'b0,
                   128'hCAFE_BABE_DEAD_BEEF_0123_4567_0000_0001};
        tbl[2] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'd1, 1'b1,
                   128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0002};
        tbl[3] = '{96'h0123_4567_89AB_CDEF_0000_0000, 16'd5, 1'b0,
                   128'h0123_4567_89AB_CDEF_0000_0000_0000_0006};

        rst         = 1'b1;
        i_start     = 1'b0;
        i_iv        = '0;
        i_num_blk   = '0;
        h_reuse     = 1'b0;
        i_aes_ready = 1'b1;
        i_aes_done  = 1'b0;
        i_ks_ready  = 1'b1;
        w_load      = 1'b0;
        w_step      = 1'b0;
        repeat (2) tick();
        chk("rst_busy0", o_busy, 0);
        chk("rst_start0", o_aes_start, 0);
        chk("rst_blk0", o_aes_blk, 0);
        chk("rst_sel0", o_aes_sel, 0);
        chk("rst_done0", o_done, 0);
        rst = 1'b0;
        tick();

        i_aes_done = 1'b1;
        #1;
        chk("idle_stray_h", o_h_valid, 0);
        chk("idle_stray_ks", o_ks_valid, 0);
        tick();
        i_aes_done = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i], 1'b0, -1);
            tick();
        end

        run_vec(tbl[0], 1'b0, 2);
        tick();
        run_vec(tbl[0], 1'b0, -1);
        tick();

`ifdef AES_GCM_SCHED_H_REUSE_EN
        run_vec(tbl[0], 1'b1, -1);
        tick();
`endif

        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        chk("wrap_load", w_ctr, 128'hA5A5_0000_1111_2222_3333_4444_FFFF_FFFF);
        w_step = 1'b1;
        tick();
        w_step = 1'b0;
        chk("wrap_low_word", w_ctr, 128'hA5A5_0000_1111_2222_3333_4444_0000_0000);
        chk("wrap_rem_last", w_rem_last, 1);
        w_step = 1'b1;
        tick();
        w_step = 1'b0;
        chk("wrap_after", w_ctr, 128'hA5A5_0000_1111_2222_3333_4444_0000_0001);
        chk("wrap_rem_zero", w_rem_zero, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
